// File: rtl/stream_overflow_accumulator.sv
// Frame-based overflow-stop accumulator: sums a valid/ready word stream until the
// next addition would carry out of WIDTH bits, then emits one registered result beat.
module stream_overflow_accumulator #(
  parameter  int WIDTH     = 4,
  parameter  int MAX_TERMS = 4,
  localparam int CNT_W     = $clog2(MAX_TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

  state_t           state, state_nxt;
  logic             up;
  logic [WIDTH-1:0] acc, acc_nxt;
  // ridx = retained terms - 1, aidx = accepted words - 1; both fit CNT_W
  logic [CNT_W-1:0] ridx, ridx_nxt, aidx, aidx_nxt, aidx_step;
  logic             ovf, ovf_nxt;
  res_t             res, res_nxt;
  logic [WIDTH:0]   t;
  logic             acc_in, term;

  assign in_ready     = up && (state != RESULT);
  assign acc_in       = in_valid && in_ready;
  assign out_valid    = (state == RESULT);
  assign out_sum      = res.sum;
  assign out_count    = res.count;
  assign out_overflow = res.ovf;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ridx_nxt  = ridx;
    aidx_nxt  = aidx;
    ovf_nxt   = ovf;
    res_nxt   = res;
    t         = {1'b0, acc} + {1'b0, in_data};
    aidx_step = (state == IDLE) ? '0 : aidx + CNT_W'(1);
    term      = acc_in && (in_last || (aidx_step == LAST_IDX));

    case (state)
      IDLE: if (acc_in) begin
        acc_nxt   = in_data;
        ridx_nxt  = '0;
        aidx_nxt  = '0;
        ovf_nxt   = 1'b0;
        state_nxt = term ? RESULT : ACCUM;
      end
      ACCUM: if (acc_in) begin
        aidx_nxt = aidx_step;
        if (!t[WIDTH]) begin
          acc_nxt  = t[WIDTH-1:0];
          ridx_nxt = ridx + CNT_W'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
        state_nxt = term ? RESULT : (ovf_nxt ? DRAIN : ACCUM);
      end
      DRAIN: if (acc_in) begin
        aidx_nxt = aidx_step;
        if (term) state_nxt = RESULT;
      end
      RESULT: if (out_ready) begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        ridx_nxt  = '0;
        aidx_nxt  = '0;
        ovf_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    // A lone first word that overflowed against the second reports zero sum
    if (term) begin
      res_nxt.sum   = ((ridx_nxt == '0) && ovf_nxt) ? '0 : acc_nxt;
      res_nxt.count = ridx_nxt;
      res_nxt.ovf   = ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      up    <= 1'b0;
      acc   <= '0;
      ridx  <= '0;
      aidx  <= '0;
      ovf   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      up    <= 1'b1;
      acc   <= acc_nxt;
      ridx  <= ridx_nxt;
      aidx  <= aidx_nxt;
      ovf   <= ovf_nxt;
      res   <= res_nxt;
    end
  end

endmodule

// File: doc/stream_overflow_accumulator.md
Name: stream_overflow_accumulator

Overview:
- Sequential, parametrised successor to the four-input overflow-stop adder.
- Accepts a frame of up to MAX_TERMS unsigned WIDTH-bit words over a valid/ready stream.
- Accumulates words in arrival order until the next addition would overflow WIDTH bits, then reports sum, count and overflow as one registered result beat.
- Sits between an operand source and any result consumer in the lab datapath; with default parameters the result semantics equal the legacy 4×4-bit adder.

Parameters:
- WIDTH, 4, operand and sum width in bits (≥2).
- MAX_TERMS, 4, maximum words per frame (≥2).
- CNT_W, $clog2(MAX_TERMS), width of out_count (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_last are valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  operand word, unsigned
- in_last  input  1  marks final word of frame
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  accumulated sum
- out_count  output  CNT_W  index of last retained term (terms retained − 1)
- out_overflow  output  1  frame was truncated by overflow

Behaviour:
- Reset, asynchronous, rst_n=0:
  - State goes to IDLE; accumulator and term counter cleared.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0, in_ready=0 while rst_n=0.
  - in_ready=1 from the first clock edge after release.
- Handshake:
  - A word transfers on a rising edge with in_valid & in_ready.
  - A result transfers on a rising edge with out_valid & out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Terminating beat: an accepted word with in_last=1, or the MAX_TERMS-th accepted word of the frame, whichever comes first.
- State machine:
  - IDLE (in_ready=1): on accept, acc←in_data, retained←1.
    - If terminating: go to RESULT.
    - Else: go to ACCUM.
  - ACCUM (in_ready=1): on accept, form the (WIDTH+1)-bit sum t = acc + in_data.
    - t[WIDTH]=0: acc←t[WIDTH-1:0], retained++.
    - t[WIDTH]=1: word discarded, ovf←1.
    - Terminating: go to RESULT. Else if ovf: go to DRAIN. Else stay in ACCUM.
  - DRAIN (in_ready=1): accept and discard words with no arithmetic; go to RESULT on the terminating beat.
  - RESULT (in_ready=0): out_valid=1; on out_ready, go to IDLE and clear acc, retained and ovf.
- Result encoding, registered on entry to RESULT; out_valid rises the cycle after the terminating beat:
  - retained ≥ 2: out_sum=acc, out_count=retained−1.
  - retained = 1 with ovf=1 (first pair overflows): out_sum=0, out_count=0. This is legacy-compatible.
  - retained = 1 with ovf=0 (single-word frame): out_sum=in word, out_count=0.
  - out_overflow=ovf in all cases.
- Width rules:
  - Overflow means a carry out of WIDTH bits only; a sum exactly equal to 2^WIDTH−1 is legal.
  - Counters never wrap, because the frame is bounded by MAX_TERMS.
- Boundary conditions:
  - in_last on the MAX_TERMS-th word counts as a single terminating event.
  - Overflow on the terminating beat goes straight to RESULT, not DRAIN.
  - Words presented in RESULT are not accepted (in_ready=0); the source must hold them.
  - After a result handshake the block returns to IDLE and is ready the following cycle.
  - rst_n asserted in any state aborts the frame immediately; no partial result is emitted.
  - in_valid=0 gaps inside a frame are allowed in every state.

Test Plan:
- Default params, frame 1,2,3,4 (last on 4) → one result beat: sum=10, count=2'b11, overflow=0; out_valid rises 1 cycle after the 4th word.
- Default params, frames 15,1,2,3 and 14,3,5,6 → each gives sum=0, count=00, overflow=1; words 3–4 accepted in DRAIN.
- Default params:
  - Frame 4,4,8,1 → sum=8, count=01, overflow=1.
  - Frame 2,9,3,5 → sum=14, count=10, overflow=1 (overflow on the terminating beat, no DRAIN).
  - Frame 3,3,3,3 → sum=12, count=11, overflow=0.
- WIDTH=8, MAX_TERMS=6, frame 100,100,55 (last on 55) → sum=255, count=3'b010, overflow=0. Then single-word frame 7 → sum=7, count=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles during RESULT → in_ready=0 and out_* stable throughout. On out_ready=1, in_ready returns 1 on the next cycle and the next frame accumulates correctly.
- Reset mid-frame: pulse rst_n low asynchronously after 2 words → out_valid=0 immediately, no result emitted. A new frame 1,1 (last) → sum=2, count=01.
